// File: rtl/flag_scan_ctrl.sv
// Flag-generation controller: scans a captured ALU result for zero one CHUNK slice
// per cycle (LSB first, early exit), commits NZCV, and evaluates ARM condition codes.
module flag_scan_ctrl #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in,
  input  logic             overflow_in,
  input  logic             set_flags,
  output logic             done,
  output logic             zero_result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  input  logic [3:0]       cond,
  output logic             cond_valid,
  output logic             cond_true
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  typedef struct packed {
    logic n;
    logic c;
    logic v;
    logic sf;
  } cap_t;

  state_t                         state;
  logic [NSLICE-1:0][CHUNK-1:0]   res;
  cap_t                           cap;
  logic [IW-1:0]                  idx;
  logic                           slice_nz;

  assign slice_nz   = |res[idx];
  assign req_ready  = (state == IDLE);
  assign cond_valid = (state == IDLE);
  assign done       = (state == COMMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      res         <= '0;
      cap         <= '0;
      idx         <= '0;
      zero_result <= 1'b0;
      flag_n      <= 1'b0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      flag_v      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          res   <= result;
          cap   <= {result[WIDTH-1], carry_in, overflow_in, set_flags};
          idx   <= '0;
          state <= SCAN;
        end
        SCAN: begin
          // zero_result is loaded on the exit edge so it is already valid while done is high
          if (slice_nz) begin
            zero_result <= 1'b0;
            state       <= COMMIT;
          end else if (idx == LAST) begin
            zero_result <= 1'b1;
            state       <= COMMIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        COMMIT: begin
          if (cap.sf) begin
            flag_n <= cap.n;
            flag_z <= zero_result;
            flag_c <= cap.c;
            flag_v <= cap.v;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cond_true = 1'b1;
    case (cond)
      4'b0000: cond_true = flag_z;
      4'b0001: cond_true = !flag_z;
      4'b0010: cond_true = flag_c;
      4'b0011: cond_true = !flag_c;
      4'b0100: cond_true = flag_n;
      4'b0101: cond_true = !flag_n;
      4'b0110: cond_true = flag_v;
      4'b0111: cond_true = !flag_v;
      4'b1000: cond_true = flag_c & !flag_z;
      4'b1001: cond_true = !flag_c | flag_z;
      4'b1010: cond_true = (flag_n == flag_v);
      4'b1011: cond_true = (flag_n != flag_v);
      4'b1100: cond_true = !flag_z & (flag_n == flag_v);
      4'b1101: cond_true = flag_z | (flag_n != flag_v);
      default: cond_true = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_flag_scan_ctrl.sv
// Randomized self-checking bench for flag_scan_ctrl against a result-level model.
module tb_flag_scan_ctrl;
  localparam int W  = 64;
  localparam int CH = 16;
  localparam int NS = W / CH;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] result;
  logic         carry_in, overflow_in, set_flags;
  logic         done, zero_result;
  logic         flag_n, flag_z, flag_c, flag_v;
  logic [3:0]   cond;
  logic         cond_valid, cond_true;

  int errors = 0;
  int checks = 0;
  logic en, ez, ec, ev;

  flag_scan_ctrl #(.WIDTH(W), .CHUNK(CH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .result(result), .carry_in(carry_in), .overflow_in(overflow_in),
    .set_flags(set_flags), .done(done), .zero_result(zero_result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .cond(cond), .cond_valid(cond_valid), .cond_true(cond_true)
  );

  always #5 clk = ~clk;

  // Scan length: position of the first nonzero slice (1-based), or NS for all-zero.
  function automatic int exp_k(input logic [W-1:0] r);
    for (int i = 0; i < NS; i++)
      if (((r >> (i * CH)) & {{(W-CH){1'b0}}, {CH{1'b1}}}) != '0) return i + 1;
    return NS;
  endfunction

  // ARM encoding: cond[3:1] picks the base test, cond[0] inverts it (except 1111).
  function automatic logic cond_model(input logic [3:0] c, input logic n, z, cf, v);
    logic b;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cf;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cf && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return (c[0] && c != 4'hF) ? !b : b;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after the op.
  task automatic run_op(input logic [W-1:0] r, input logic c, v, sf,
                        input logic hold, input logic [W-1:0] nxt);
    int k;
    k = exp_k(r);
    req_valid = 1'b1; result = r; carry_in = c; overflow_in = v; set_flags = sf;
    cond = 4'($urandom);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_at_req got=%b exp=1", req_ready); end
    @(posedge clk);
    for (int cyc = 1; cyc <= k + 1; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        if (hold) result = nxt;
        else begin
          req_valid = 1'b0; result = {$urandom, $urandom};
          carry_in = 1'($urandom); overflow_in = 1'($urandom); set_flags = 1'($urandom);
        end
      end
      checks++;
      if (done !== (cyc == k + 1)) begin
        errors++; $display("FAIL done_timing cyc=%0d got=%b exp=%b", cyc, done, cyc == k + 1);
      end
      checks++;
      if (req_ready !== 1'b0 || cond_valid !== 1'b0) begin
        errors++; $display("FAIL busy_cyc%0d ready=%b cond_valid=%b exp=0/0", cyc, req_ready, cond_valid);
      end
      if (cyc == k + 1) begin
        checks++;
        if (zero_result !== (r == '0)) begin
          errors++; $display("FAIL zero_result r=%h got=%b exp=%b", r, zero_result, r == '0);
        end
      end
    end
    if (sf) begin en = r[W-1]; ez = (r == '0); ec = c; ev = v; end
    @(negedge clk);
    checks++;
    if ({flag_n, flag_z, flag_c, flag_v} !== {en, ez, ec, ev}) begin
      errors++; $display("FAIL flags r=%h got=%b%b%b%b exp=%b%b%b%b", r,
        flag_n, flag_z, flag_c, flag_v, en, ez, ec, ev);
    end
    checks++;
    if (req_ready !== 1'b1 || cond_valid !== 1'b1 || done !== 1'b0 || zero_result !== (r == '0)) begin
      errors++; $display("FAIL idle_after ready=%b cv=%b done=%b zr=%b exp=1/1/0/%b",
        req_ready, cond_valid, done, zero_result, r == '0);
    end
    checks++;
    if (cond_true !== cond_model(cond, en, ez, ec, ev)) begin
      errors++; $display("FAIL cond_rand cond=%h got=%b exp=%b", cond, cond_true, cond_model(cond, en, ez, ec, ev));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; result = '0; carry_in = 0; overflow_in = 0;
    set_flags = 0; cond = 4'h0;
    #1;
    checks++;
    if ({req_ready, cond_valid, done, zero_result, flag_n, flag_z, flag_c, flag_v} !== 8'b1100_0000) begin
      errors++; $display("FAIL reset_state got=%b exp=11000000",
        {req_ready, cond_valid, done, zero_result, flag_n, flag_z, flag_c, flag_v});
    end
    en = 0; ez = 0; ec = 0; ev = 0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_zero();
    run_op(64'h0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0110) begin
      errors++; $display("FAIL all_zero_flags got=%b%b%b%b exp=0110", flag_n, flag_z, flag_c, flag_v);
    end
  endtask

  task automatic test_early_exit();
    run_op(64'hC0FFEE3949039248, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if ({flag_n, flag_z} !== 2'b10) begin
      errors++; $display("FAIL early_exit_nz got=%b%b exp=10", flag_n, flag_z);
    end
  endtask

  task automatic test_no_set_flags();
    run_op(64'h3C3C000000000000, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    checks++;
    if ({flag_n, flag_z, flag_c, flag_v} !== 4'b1000) begin
      errors++; $display("FAIL no_set_flags got=%b%b%b%b exp=1000", flag_n, flag_z, flag_c, flag_v);
    end
  endtask

  task automatic test_cond_sweep();
    logic [3:0] cs [8] = '{4'h0, 4'h1, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    logic       ex [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      cond = cs[i]; #1;
      checks++;
      if (cond_true !== ex[i]) begin
        errors++; $display("FAIL cond_fixed cond=%h got=%b exp=%b", cs[i], cond_true, ex[i]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      cond = 4'(i); #1;
      checks++;
      if (cond_true !== cond_model(4'(i), en, ez, ec, ev)) begin
        errors++; $display("FAIL cond_sweep cond=%h got=%b exp=%b", i, cond_true, cond_model(4'(i), en, ez, ec, ev));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    a = 64'h0000_0000_1234_0000;
    b = 64'h8000_0000_0000_0000;
    run_op(a, 1'b0, 1'b1, 1'b1, 1'b1, b);
    run_op(b, 1'b1, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic test_random();
    logic [W-1:0] r;
    int nz;
    for (int t = 0; t < 40; t++) begin
      r = {$urandom, $urandom};
      nz = $urandom_range(0, NS);
      for (int s = 0; s < nz; s++) r[s*CH +: CH] = '0;
      run_op(r, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0);
    end
  endtask

  task automatic test_reset_mid_scan();
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; en = 0; ez = 0; ec = 0; ev = 0;
    @(negedge clk);
    req_valid = 1'b1; result = '0; carry_in = 1'b1; overflow_in = 1'b1; set_flags = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, cond_valid, done} !== 3'b110) begin
      errors++; $display("FAIL reset_mid_idle got=%b exp=110", {req_ready, cond_valid, done});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NS + 2; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || {flag_n, flag_z, flag_c, flag_v} !== 4'b0000 || req_ready !== 1'b1) begin
        errors++; $display("FAIL reset_mid_abort done=%b flags=%b%b%b%b ready=%b exp=0/0000/1",
          done, flag_n, flag_z, flag_c, flag_v, req_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_early_exit();
    test_no_set_flags();
    test_cond_sweep();
    test_back_to_back();
    test_random();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flag_scan_ctrl.md
Name: flag_scan_ctrl

Overview:
Multi-cycle flag-generation controller for the 64-bit ALU result path. It accepts a result through a valid/ready handshake and scans it for zero in CHUNK-wide slices, LSB slice first, exiting early at the first nonzero slice. It then commits NZCV to the architectural flag register when set_flags is requested. It also evaluates ARM condition codes against the committed flags for conditional-branch logic.

Parameters:
WIDTH, 64, result width; must be an integer multiple of CHUNK.
CHUNK, 16, slice width examined per scan cycle; NSLICE = WIDTH/CHUNK (default 4).

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  result/flag request present
req_ready  output  1  controller can accept a request
result  input  WIDTH  ALU result; sampled on the handshake only
carry_in  input  1  ALU carry-out; sampled on the handshake
overflow_in  input  1  ALU overflow; sampled on the handshake
set_flags  input  1  commit NZCV when done (ADDS/SUBS-type op); sampled on the handshake
done  output  1  one-cycle pulse; zero_result valid
zero_result  output  1  zero status of the last scanned result
flag_n, flag_z, flag_c, flag_v  output  1 each  committed architectural flags
cond  input  4  ARM condition code to evaluate
cond_valid  output  1  cond_true is meaningful; high only in IDLE
cond_true  output  1  cond evaluated against committed flags

Behaviour:
- One clock (clk). reset is asynchronous, active-high.
- Reset values: state=IDLE, slice index=0, flag_n/z/c/v=0, done=0, zero_result=0, captured regs=0. req_ready and cond_valid read 1 as soon as reset is applied, because state=IDLE.
- Reset mid-scan aborts the operation: no done pulse, no flag write.
- FSM states are IDLE, SCAN and COMMIT.
- IDLE:
  - req_ready=1.
  - When req_valid&req_ready, capture result, N=result[WIDTH-1], carry_in, overflow_in and set_flags.
  - Clear slice index to 0 and go to SCAN.
  - With req_valid=0, stay in IDLE.
- SCAN:
  - req_ready=0.
  - Each cycle, test slice idx (bits idx*CHUNK+CHUNK-1 .. idx*CHUNK) with a reduction OR.
  - Slice nonzero: zero=0, go to COMMIT (early exit).
  - Slice zero and idx==NSLICE-1: zero=1, go to COMMIT.
  - Otherwise idx++ and stay in SCAN.
- COMMIT:
  - req_ready=0, done=1, zero_result driven with the scan outcome.
  - On the exiting edge: if captured set_flags=1, load flag_n=N, flag_z=zero, flag_c=C, flag_v=V.
  - If captured set_flags=0, flags hold.
  - Always return to IDLE.
- zero_result holds its value until the next COMMIT.
- Latency, with the handshake cycle numbered C0:
  - SCAN occupies C1..Ck, where k = (index of first nonzero slice)+1, or NSLICE if the result is all-zero.
  - done is high in Ck+1.
  - Updated flags and req_ready=1 are visible in Ck+2.
  - Minimum is 3 cycles handshake-to-handshake; maximum is NSLICE+2.
- No back-to-back acceptance: the next request can only be accepted in IDLE.
- Input result may change after the handshake without affecting the scan.
- cond_true is combinational from committed flags and cond:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 and 1111: always 1.
- cond_valid = (state==IDLE). Branch logic must stall while cond_valid=0, so a branch never sees stale flags during a pending update.

Test Plan:
- After reset, result=64'h0000000000000000, set_flags=1, carry_in=1, overflow_in=0 → 4 SCAN cycles, done pulse in C5, zero_result=1; in C6 Z=1 N=0 C=1 V=0 and req_ready=1.
- result=64'hC0FFEE3949039248, set_flags=1, C=V=0 → slice 0 (0x9248) nonzero, done in C2, zero_result=0; in C3 N=1 Z=0.
- result=64'h3C3C000000000000, set_flags=0 after the previous case → done in C5, zero_result=0; flags remain N=1 Z=0 C=0 V=0.
- With committed N=1 Z=0 C=0 V=0, sweep cond → EQ=0, NE=1, MI=1, GE=0, LT=1, GT=0, LE=1, AL=1. During any scan, cond_valid=0.
- Assert reset in C2 of an all-zero scan with set_flags=1 → state=IDLE immediately, no done pulse, all flags remain 0, req_ready=1.
- Hold req_valid=1 with new data during SCAN/COMMIT → not accepted until IDLE; the second request's handshake occurs in Ck+2 and is scanned correctly.
